// File: rtl/uart_sniffer_pkg.sv
// Shared definitions for the UART receive sniffer: deserializer state
// encoding, sizing defaults and the FIFO level width.
package uart_sniffer_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 347;
  localparam int DEFAULT_FIFO_DEPTH   = 8;
  localparam int LEVEL_W              = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/sniffer_sync_fifo.sv
// Single-clock show-ahead byte FIFO with a sticky overflow flag.
// The head byte is presented combinationally and masked to zero while empty.
module sniffer_sync_fifo
  import uart_sniffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [7:0]         push_data,
  input  logic               pop,
  input  logic               clr,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_cnt;
  logic [AW:0] rd_cnt;
  logic [AW:0] used;
  logic        full;
  logic        do_pop;
  logic        do_push;
  logic        drop;

  assign used     = wr_cnt - rd_cnt;
  assign full     = (used == (AW+1)'(DEPTH));
  assign rd_valid = (used != '0);
  assign level    = LEVEL_W'(used);
  assign do_pop   = pop && rd_valid;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign rd_data  = rd_valid ? mem[rd_cnt[AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_cnt[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_sniffer.sv
// UART receive sniffer: synchronizes RXD, deserializes 8N1 frames sampled at
// mid-bit, and queues good bytes into a show-ahead FIFO for the monitor.
module uart_rx_sniffer
  import uart_sniffer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               RXD,
  input  logic               RD_EN,
  output logic [7:0]         RD_DATA,
  output logic               RD_VALID,
  output logic [LEVEL_W-1:0] FIFO_LEVEL,
  output logic               FRAME_ERR,
  output logic               OVERFLOW,
  input  logic               CLR
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);

  rx_state_t   state, state_next;
  logic        rxd_meta, rxd_s;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic [7:0]  shreg, shreg_next;
  logic        expired;
  logic        push;
  logic        frame_err_next;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shreg     <= shreg_next;
      FRAME_ERR <= frame_err_next;
    end
  end

  assign expired = (cnt == 16'd1);

  // The half-bit start delay centres every later sample in its bit cell.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    idx_next       = idx;
    shreg_next     = shreg;
    push           = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_next = START;
          cnt_next   = HALF_BIT;
        end
      end
      START: begin
        if (!expired) begin
          cnt_next = cnt - 16'd1;
        end else if (!rxd_s) begin
          state_next = DATA;
          cnt_next   = FULL_BIT;
          idx_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (!expired) begin
          cnt_next = cnt - 16'd1;
        end else begin
          shreg_next = {rxd_s, shreg[7:1]};
          cnt_next   = FULL_BIT;
          idx_next   = idx + 3'd1;
          if (idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (!expired) begin
          cnt_next = cnt - 16'd1;
        end else if (rxd_s) begin
          push       = 1'b1;
          state_next = IDLE;
        end else begin
          frame_err_next = 1'b1;
          state_next     = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxd_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  sniffer_sync_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RSTN),
    .push     (push),
    .push_data(shreg),
    .pop      (RD_EN),
    .clr      (CLR),
    .rd_data  (RD_DATA),
    .rd_valid (RD_VALID),
    .level    (FIFO_LEVEL),
    .overflow (OVERFLOW)
  );

endmodule

// File: doc/uart_rx_sniffer.md
UART_RX_SNIFFER -- requirements
Module: uart_rx_sniffer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 347 (40 MHz / 115200): CLK cycles per UART bit; legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: receive FIFO entries; fixed power of two.
REQ-003 Port CLK  input  1: the only clock; all logic samples on the rising edge.
REQ-004 Port RSTN  input  1: reset, asynchronous assertion, active-low.
REQ-005 Port RXD  input  1: serial line driven by the MCU TXD pin; asynchronous to CLK; idle high.
REQ-006 Port RD_EN  input  1: pop request from the consumer (the sim monitor).
REQ-007 Port RD_DATA  output  8: FIFO head byte; valid only while RD_VALID=1.
REQ-008 Port RD_VALID  output  1: FIFO not empty.
REQ-009 Port FIFO_LEVEL  output  4: number of stored bytes, 0..8.
REQ-010 Port FRAME_ERR  output  1: one-cycle pulse on a bad stop bit.
REQ-011 Port OVERFLOW  output  1: sticky flag, set when a byte is dropped because the FIFO is full.
REQ-012 Port CLR  input  1: synchronous clear of OVERFLOW.

Function
REQ-013 RXD SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decoding uses the synchronized value rxd_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE->START when rxd_s=0; the bit counter loads CLKS_PER_BIT/2 (integer division).
REQ-016 START: at counter expiry, if rxd_s=0 go to DATA and load CLKS_PER_BIT; else treat as a glitch, return to IDLE, and produce no output.
REQ-017 DATA: sample rxd_s at each CLKS_PER_BIT expiry, LSB first, 8 samples, then go to STOP and reload CLKS_PER_BIT.
REQ-018 STOP: at expiry, if rxd_s=1 push the byte and go to IDLE.
REQ-019 STOP: at expiry, if rxd_s=0 pulse FRAME_ERR for exactly one cycle, discard the byte, and go to WAIT_IDLE.
REQ-020 WAIT_IDLE->IDLE on the first cycle with rxd_s=1, so a break condition is never decoded as bytes.
REQ-021 A pushed byte SHALL appear at RD_DATA with RD_VALID=1 on the cycle after the stop-bit sample.
REQ-022 FIFO SHALL be show-ahead: RD_DATA always presents the oldest byte; RD_EN=1 with RD_VALID=1 pops at that edge.
REQ-023 RD_EN while empty SHALL be ignored: no pointer or level change, RD_DATA holds.
REQ-024 Push while full without a same-cycle pop: byte dropped, OVERFLOW set, stored data unchanged.
REQ-025 Push and pop in the same cycle, including when full: both take effect, level unchanged, OVERFLOW not set.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; FIFO_LEVEL = write count minus read count.
REQ-027 CLR=1 clears OVERFLOW; if an overflow occurs in the same cycle, set wins.
REQ-028 The bit counter is 16 bits wide and counts down to 1; expiry is count==1.

Reset
REQ-029 RSTN=0 SHALL force: state IDLE, counters 0, pointers 0, FIFO_LEVEL=0, RD_VALID=0, RD_DATA=8'h00, FRAME_ERR=0, OVERFLOW=0, synchronizer flops=1.
REQ-030 Reset asserted mid-frame SHALL abort the partial byte with no push; after RSTN=1 the next start bit decodes normally.
REQ-031 FIFO storage is not reset; RD_DATA is masked to 0 while RD_VALID=0.

Structure
REQ-032 A shared package/header uart_sniffer_pkg SHALL hold the FSM state encodings, the CLKS_PER_BIT and FIFO_DEPTH defaults, and the level width.
REQ-033 The FIFO SHALL be a sub-module sniffer_sync_fifo (show-ahead, single clock); the deserializer FSM stays in uart_rx_sniffer.
REQ-034 Target size: 150-300 lines total.

Verification (CLKS_PER_BIT=8)
REQ-035 Send 0x55 with a valid stop bit -> RD_DATA=0x55, RD_VALID=1, FIFO_LEVEL=1 exactly one cycle after the stop-bit sample.
REQ-036 Hold RXD low for 2 cycles, then high -> FSM returns to IDLE, FIFO_LEVEL stays 0, FRAME_ERR stays 0.
REQ-037 Send 0xA3 with stop bit 0, then hold RXD low for 40 cycles -> one FRAME_ERR pulse, FIFO_LEVEL=0, no further bytes decoded until RXD returns high.
REQ-038 Send 0x00..0x08 (9 bytes) with no reads -> FIFO_LEVEL=8, OVERFLOW=1; popping yields 0x00..0x07 in order; pulsing CLR clears OVERFLOW.
REQ-039 With the FIFO full, assert RD_EN on the push cycle of 0x5A -> FIFO_LEVEL stays 8, OVERFLOW=0, 0x5A is read last.
REQ-040 Assert RSTN low during data bit 4 of 0xFF, release it, then send 0x3C -> all outputs at reset values while RSTN=0; afterwards exactly one byte, 0x3C, is received.
